// File: rtl/op_share_if.sv
// Request/result bus for op_share_arbiter: NREQ packed requester lanes in, one result out.
interface op_share_if #(
  parameter int W    = 8,
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_op;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [IW-1:0]     res_id;
  logic              res_flag;

  modport master (
    output req_valid, req_a, req_b, req_op, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_flag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, res_ready,
    output req_ready, res_valid, res_data, res_id, res_flag
  );
endinterface

// File: rtl/op_share_arbiter.sv
// Round-robin arbiter in front of one shared (A&B)+1 / (A|B)-1 unit, one op in flight.
// Optional carry/borrow flag on res_flag when OP_SHARE_RESULT_FLAG_EN is defined.
//
// state | meaning
// IDLE  | searching for a requester; req_ready pulses combinationally on the grant
// CALC  | operands captured, intermediate (A&B or A|B) evaluated
// OUT   | result presented, held until res_ready
module op_share_arbiter #(
  parameter int W    = 8,
  parameter int NREQ = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  op_share_if.slave   bus,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int IW = $clog2(NREQ);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] ready_c;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_op;
  logic [W-1:0]    a_q, b_q;
  logic            op_q;
  logic [IW-1:0]   id_q;
  logic [W-1:0]    mid;
  logic            res_valid_q;
  logic [W-1:0]    res_data_q;
  logic [IW-1:0]   res_id_q;

  // Search starts one past the last winner and wraps, so a held request waits at most NREQ-1 ops.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(last_grant) + 1 + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && bus.req_valid[IW'(j)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        sel_a  = bus.req_a[i*W +: W];
        sel_b  = bus.req_b[i*W +: W];
        sel_op = bus.req_op[i];
      end
    end
  end

  // rst_n gates the grant so req_ready is low throughout reset, not just after the first edge.
  always_comb begin
    ready_c = '0;
    if (rst_n && state == IDLE && gnt_any) ready_c[gnt_idx] = 1'b1;
  end

  assign mid = op_q ? (a_q | b_q) : (a_q & b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IW'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      op_count    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            op_q       <= sel_op;
            id_q       <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= CALC;
          end
        end
        CALC: begin
          res_data_q  <= op_q ? (mid - ONE) : (mid + ONE);
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_count    <= op_count + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OP_SHARE_RESULT_FLAG_EN
  logic flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             flag_q <= 1'b0;
    else if (state == CALC) flag_q <= op_q ? (mid == '0) : (&mid);
  end

  assign bus.res_flag = flag_q;
`else
  assign bus.res_flag = 1'b0;
`endif

  assign bus.req_ready = ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign busy          = (state != IDLE);
endmodule
